// File: rtl/i2c_types_pkg.sv
// rtl/i2c_types_pkg.sv - shared I2C command and engine state types
package i2c_types_pkg;

    typedef enum logic [2:0] {
        CMD_START     = 3'd1,
        CMD_STOP      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_READ_ACK  = 3'd4,
        CMD_READ_NACK = 3'd5
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_BYTE
    } eng_state_t;

    function automatic logic is_read(input i2c_cmd_t cmd);
        return (cmd == CMD_READ_ACK) || (cmd == CMD_READ_NACK);
    endfunction

endpackage

// File: rtl/i2c_master_engine_quarter_timer.sv
// rtl/i2c_master_engine_quarter_timer.sv - SCL quarter-period prescaler with stretch hold
module i2c_quarter_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic hold_i,
    output logic quarter_end_o
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // A stretched quarter restarts its count once the target lets SCL go
    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i || hold_i || quarter_end_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign quarter_end_o = run_i & ~hold_i & (r_cnt == CNT_MAX);

endmodule

// File: rtl/i2c_master_engine.sv
// rtl/i2c_master_engine.sv - byte-level I2C initiator driving open-drain SCL/SDA
module i2c_master_engine
    import i2c_types_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int I2C_DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2:0]                cmd_i,
    input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
    output logic [I2C_DATA_WIDTH-1:0] rdata_o,
    output logic                      done_o,
    output logic                      nack_o,
    output logic                      err_o,
    output logic                      busy_o,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o
);
    localparam logic [3:0] SLOT_LAST = 4'(I2C_DATA_WIDTH);

    eng_state_t                r_state, w_next;
    i2c_cmd_t                  r_cmd, w_cmd;
    logic [1:0]                r_q;
    logic [3:0]                r_slot;
    logic [I2C_DATA_WIDTH-1:0] r_shift, r_rdata;
    logic r_bit, r_nack, r_done, r_err, r_busy, r_ready, r_park_scl, r_park_sda;
    logic w_accept, w_illegal, w_qend, w_finish, w_scl, w_sda;

    assign w_cmd     = i2c_cmd_t'(cmd_i);
    assign w_accept  = cmd_valid_i & r_ready;
    assign w_illegal = !((w_cmd == CMD_START) ||
                         (r_busy && (w_cmd inside {CMD_STOP, CMD_WRITE, CMD_READ_ACK, CMD_READ_NACK})));
    assign w_finish  = w_qend && (r_q == 2'd3) && ((r_state != ST_BYTE) || (r_slot == SLOT_LAST));

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .run_i         (r_state != ST_IDLE),
        .hold_i        (w_scl & ~scl_i),
        .quarter_end_o (w_qend)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ST_IDLE);
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE) begin
            if (w_accept && !w_illegal) begin
                case (w_cmd)
                    CMD_START: w_next = ST_START;
                    CMD_STOP:  w_next = ST_STOP;
                    default:   w_next = ST_BYTE;
                endcase
            end
        end else if (w_finish) begin
            w_next = ST_IDLE;
        end
    end

    // Between commands the bus parks on whatever the last quarter drove
    always_comb begin
        w_scl = r_park_scl;
        w_sda = r_park_sda;
        case (r_state)
            ST_START: begin
                w_scl = (r_q == 2'd0) ? r_park_scl : (r_q != 2'd3);
                w_sda = ~r_q[1];
            end
            ST_STOP: begin
                w_scl = (r_q != 2'd0);
                w_sda = r_q[1];
            end
            ST_BYTE: begin
                w_scl = r_q[0] ^ r_q[1];
                if (r_slot == SLOT_LAST) begin
                    w_sda = (r_cmd != CMD_READ_ACK);
                end else begin
                    w_sda = (r_cmd == CMD_WRITE) ? r_shift[I2C_DATA_WIDTH-1] : 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmd      <= CMD_START;
            r_q        <= 2'd0;
            r_slot     <= 4'd0;
            r_shift    <= '0;
            r_rdata    <= '0;
            r_bit      <= 1'b1;
            r_nack     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_park_scl <= 1'b1;
            r_park_sda <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_cmd   <= w_cmd;
                    r_q     <= 2'd0;
                    r_slot  <= 4'd0;
                    r_shift <= wdata_i;
                    r_done  <= w_illegal;
                    r_err   <= w_illegal;
                end
            end else if (w_qend) begin
                r_q <= r_q + 2'd1;
                if (r_q == 2'd2) begin
                    r_bit <= sda_i;
                end
                if (r_q == 2'd3) begin
                    r_slot <= r_slot + 4'd1;
                    if (r_slot < SLOT_LAST) begin
                        r_shift <= {r_shift[I2C_DATA_WIDTH-2:0], r_bit};
                    end
                end
                if (w_finish) begin
                    r_done     <= 1'b1;
                    r_park_scl <= w_scl;
                    r_park_sda <= w_sda;
                    case (r_state)
                        ST_START: r_busy <= 1'b1;
                        ST_STOP:  r_busy <= 1'b0;
                        default: begin
                            if (is_read(r_cmd)) r_rdata <= r_shift;
                            else                r_nack  <= r_bit;
                        end
                    endcase
                end
            end
        end
    end

    assign cmd_ready_o = r_ready;
    assign rdata_o     = r_rdata;
    assign done_o      = r_done;
    assign nack_o      = r_nack;
    assign err_o       = r_err;
    assign busy_o      = r_busy;
    assign scl_o       = w_scl;
    assign sda_o       = w_sda;

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb/tb_i2c_master_engine.sv - randomized self-checking bench for i2c_master_engine
module tb_i2c_master_engine;
    import i2c_types_pkg::*;

    localparam int CLK_DIV = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i = 1'b0;
    logic [2:0] cmd_i = 3'd0;
    logic [7:0] wdata_i = 8'd0;
    logic       cmd_ready_o, done_o, nack_o, err_o, busy_o, scl_o, sda_o;
    logic [7:0] rdata_o;
    logic       scl_i, sda_i;
    bit         r_resp = 1'b1;
    bit         r_stretch = 1'b0;

    // Open-drain bus: the target side can only pull lines low
    assign scl_i = scl_o & ~r_stretch;
    assign sda_i = sda_o & r_resp;

    always #5 clk_i = ~clk_i;

    i2c_master_engine #(.CLK_DIV(CLK_DIV), .I2C_DATA_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_i       (cmd_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .nack_o      (nack_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl_o       (scl_o),
        .sda_o       (sda_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    bit         m_busy, m_scl, m_sda, m_nack;
    logic [7:0] m_rdata;
    bit         e_scl[$], e_sda[$], e_resp[$], e_str[$];
    int         r_lat;
    bit         r_first_scl;

    i2c_cmd_t   g_cmd;
    int         g_sel, g_slot, g_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_q(input bit sda, input bit scl, input bit resp, input int stretch);
        for (int i = 0; i < stretch + CLK_DIV; i++) begin
            e_scl.push_back(scl);
            e_sda.push_back(sda);
            e_resp.push_back(resp);
            e_str.push_back(i < stretch);
        end
    endtask

    task automatic push_slot(input bit d, input bit resp, input int stretch);
        push_q(d, 1'b0, resp, 0);
        push_q(d, 1'b1, resp, stretch);
        push_q(d, 1'b1, resp, 0);
        push_q(d, 1'b0, resp, 0);
    endtask

    // data: byte to write, or byte the target returns on a read; ack: target acks a write
    task automatic do_cmd(input i2c_cmd_t cmd, input logic [7:0] data, input bit ack,
                          input int st_slot, input int st_n);
        bit         legal, exp_busy, exp_nack;
        logic [7:0] exp_rd;
        int         len;
        e_scl.delete(); e_sda.delete(); e_resp.delete(); e_str.delete();
        legal    = (cmd == CMD_START) || m_busy;
        exp_busy = m_busy;
        exp_nack = m_nack;
        exp_rd   = m_rdata;
        if (legal) begin
            case (cmd)
                CMD_START: begin
                    push_q(1, m_scl, 1, 0); push_q(1, 1, 1, 0); push_q(0, 1, 1, 0); push_q(0, 0, 1, 0);
                    exp_busy = 1'b1;
                end
                CMD_STOP: begin
                    push_q(0, 0, 1, 0); push_q(0, 1, 1, 0); push_q(1, 1, 1, 0); push_q(1, 1, 1, 0);
                    exp_busy = 1'b0;
                end
                CMD_WRITE: begin
                    for (int i = 0; i < 8; i++) push_slot(data[7-i], 1'b1, (i == st_slot) ? st_n : 0);
                    push_slot(1'b1, !ack, (st_slot == 8) ? st_n : 0);
                    exp_nack = !ack;
                end
                default: begin
                    for (int i = 0; i < 8; i++) push_slot(1'b1, data[7-i], (i == st_slot) ? st_n : 0);
                    push_slot(cmd == CMD_READ_NACK, 1'b1, (st_slot == 8) ? st_n : 0);
                    exp_rd = data;
                end
            endcase
        end
        len = e_scl.size();
        chk("ready_before_cmd", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_i       = cmd;
        wdata_i     = (cmd == CMD_WRITE) ? data : 8'($urandom);
        @(posedge clk_i);
        r_lat = -1;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
            cmd_i       = 3'($urandom);
            if (k == 0) r_first_scl = scl_o;
            if (done_o && r_lat < 0) r_lat = k;
            if (k < len) begin
                r_resp    = e_resp[k];
                r_stretch = e_str[k];
                chk("bus", {scl_o, sda_o, done_o, err_o, cmd_ready_o, busy_o},
                    {e_scl[k], e_sda[k], 1'b0, 1'b0, 1'b0, m_busy});
            end else begin
                r_resp    = 1'b1;
                r_stretch = 1'b0;
                chk("done", {done_o, err_o, cmd_ready_o, busy_o}, {1'b1, !legal, 1'b1, exp_busy});
                chk("rdata", rdata_o, exp_rd);
                chk("nack", nack_o, exp_nack);
                if (!legal) chk("illegal_bus", {scl_o, sda_o}, {m_scl, m_sda});
            end
        end
        if (legal) begin
            m_scl = e_scl[len-1];
            m_sda = e_sda[len-1];
        end
        m_busy  = exp_busy;
        m_nack  = exp_nack;
        m_rdata = exp_rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            chk("idle", {scl_o, sda_o, done_o, err_o, cmd_ready_o, busy_o},
                {m_scl, m_sda, 1'b0, 1'b0, 1'b1, m_busy});
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; cmd_valid_i = 1'b0; r_resp = 1'b1; r_stretch = 1'b0;
        @(negedge clk_i);
        chk("reset_outputs", {scl_o, sda_o, cmd_ready_o, done_o, nack_o, err_o, busy_o}, 7'b1100000);
        chk("reset_rdata", rdata_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_reset", cmd_ready_o, 1);
        m_busy = 1'b0; m_scl = 1'b1; m_sda = 1'b1; m_nack = 1'b0; m_rdata = 8'd0;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        do_reset();

        do_cmd(CMD_WRITE, 8'h44, 1'b1, -1, 0);
        chk("illegal_lat", r_lat, 0);
        idle(2);
        do_cmd(CMD_START, 8'h00, 1'b0, -1, 0);
        chk("start_lat", r_lat, 16);
        do_cmd(CMD_WRITE, 8'h44, 1'b1, -1, 0);
        chk("write_lat", r_lat, 144);
        chk("write_nack", nack_o, 0);
        do_cmd(CMD_WRITE, 8'hA5, 1'b1, 3, 20);
        chk("stretch_lat", r_lat, 164);
        do_cmd(CMD_START, 8'h00, 1'b0, -1, 0);
        chk("restart_first_scl", r_first_scl, 0);
        do_cmd(CMD_WRITE, 8'h45, 1'b1, -1, 0);
        do_cmd(CMD_READ_ACK, 8'h3C, 1'b0, -1, 0);
        chk("read_ack_data", rdata_o, 8'h3C);
        do_cmd(CMD_READ_NACK, 8'hC3, 1'b0, -1, 0);
        chk("read_nack_data", rdata_o, 8'hC3);
        do_cmd(CMD_STOP, 8'h00, 1'b0, -1, 0);
        chk("stop_busy", busy_o, 0);
        idle(3);
        do_cmd(CMD_START, 8'h00, 1'b0, -1, 0);
        do_cmd(CMD_WRITE, 8'h46, 1'b0, -1, 0);
        chk("miss_nack", nack_o, 1);
        do_cmd(CMD_STOP, 8'h00, 1'b0, -1, 0);

        do_cmd(CMD_START, 8'h00, 1'b0, -1, 0);
        cmd_valid_i = 1'b1; cmd_i = CMD_WRITE; wdata_i = 8'h55;
        @(posedge clk_i);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
        end
        do_reset();

        for (int n = 0; n < 80; n++) begin
            g_sel = $urandom_range(0, 9);
            if (!m_busy && g_sel < 7) g_cmd = CMD_START;
            else begin
                case (g_sel % 5)
                    0:       g_cmd = CMD_START;
                    1:       g_cmd = CMD_STOP;
                    2:       g_cmd = CMD_WRITE;
                    3:       g_cmd = CMD_READ_ACK;
                    default: g_cmd = CMD_READ_NACK;
                endcase
            end
            g_slot = -1;
            g_n    = 0;
            if ($urandom_range(0, 3) == 0) begin
                g_slot = $urandom_range(0, 8);
                g_n    = $urandom_range(1, 20);
            end
            do_cmd(g_cmd, 8'($urandom), 1'($urandom), g_slot, g_n);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
